// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad scanner with frame debounce and key-code FIFO
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] row,
    output logic [3:0] column,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_pop,
    output logic [4:0] fifo_count,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic       interrupt
);
    localparam int         DW       = $clog2(SCAN_DIV);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] CNT_MAX  = 4'(DEBOUNCE_CNT);
    localparam logic [4:0] FULL_CNT = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, EVAL} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_KEY, CLS_MULTI} cls_t;

    state_t        state, state_nxt;
    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic [15:0]   frame;
    cls_t          cand_cls, acc_cls, frm_cls;
    logic [3:0]    cand_code, acc_code, frm_code, stable_cnt, new_cnt, key_idx;
    logic [4:0]    key_n;
    logic          div_done, accept, push;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          do_push, do_pop;

    assign div_done = (div == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        column    = 4'b1111;
        case (state)
            IDLE: if (enable) state_nxt = SCAN;
            SCAN: begin
                column = ~(4'b0001 << col_idx);
                if (!enable)                          state_nxt = IDLE;
                else if (div_done && col_idx == 2'd3) state_nxt = EVAL;
            end
            EVAL:    state_nxt = enable ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame bit row*4+col is set when that key reads low, so the key code is the bit index.
    always_comb begin
        key_n   = 5'd0;
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                key_n   = key_n + 5'd1;
                key_idx = 4'(i);
            end
        end
        if (key_n == 5'd0)      frm_cls = CLS_NONE;
        else if (key_n == 5'd1) frm_cls = CLS_KEY;
        else                    frm_cls = CLS_MULTI;
        frm_code = (frm_cls == CLS_KEY) ? key_idx : 4'd0;

        if (frm_cls == cand_cls && frm_code == cand_code)
            new_cnt = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 4'd1;
        else
            new_cnt = 4'd1;
        accept = (new_cnt == CNT_MAX) && (frm_cls != CLS_MULTI) &&
                 ((frm_cls != acc_cls) || (frm_code != acc_code));
        push   = (state == EVAL) && enable && accept && (frm_cls == CLS_KEY);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_s1     <= 4'b1111;
            row_s2     <= 4'b1111;
            div        <= '0;
            col_idx    <= 2'd0;
            frame      <= 16'd0;
            cand_cls   <= CLS_NONE;
            cand_code  <= 4'd0;
            stable_cnt <= 4'd0;
            acc_cls    <= CLS_NONE;
            acc_code   <= 4'd0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (!enable) begin
                div        <= '0;
                col_idx    <= 2'd0;
                frame      <= 16'd0;
                cand_cls   <= CLS_NONE;
                cand_code  <= 4'd0;
                stable_cnt <= 4'd0;
                acc_cls    <= CLS_NONE;
                acc_code   <= 4'd0;
            end else begin
                case (state)
                    SCAN: begin
                        if (div_done) begin
                            div <= '0;
                            for (int r = 0; r < 4; r++)
                                frame[{2'(r), col_idx}] <= ~row_s2[r];
                            col_idx <= col_idx + 2'd1;
                        end else begin
                            div <= div + DW'(1);
                        end
                    end
                    EVAL: begin
                        cand_cls   <= frm_cls;
                        cand_code  <= frm_code;
                        stable_cnt <= new_cnt;
                        if (accept) begin
                            acc_cls  <= frm_cls;
                            acc_code <= frm_code;
                        end
                        div     <= '0;
                        col_idx <= 2'd0;
                    end
                    default: begin
                        div     <= '0;
                        col_idx <= 2'd0;
                    end
                endcase
            end
        end
    end

    // A pop frees the slot the same cycle, so a push into a full FIFO with a pop succeeds.
    assign do_pop  = key_pop && (count != 5'd0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {4'd0, do_push} - {4'd0, do_pop};
            if (push && !do_push)  overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= frm_code;
    end

    assign key_valid  = (count != 5'd0);
    assign key_code   = key_valid ? mem[rd_ptr] : 4'd0;
    assign fifo_count = count;
    assign interrupt  = key_valid;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - randomized and directed bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       reset, enable, key_pop, overflow_clr;
    logic [3:0] row, column, key_code;
    logic       key_valid, overflow, interrupt;
    logic [4:0] fifo_count;

    logic [15:0] pressed;
    logic        force_row_low;

    logic [3:0]  exp_q[$];
    logic [15:0] hist[$];
    logic [15:0] acc;
    logic        exp_ovf;
    int          n_vec = 0;
    int          n_err = 0;

    keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .row(row), .column(column),
        .key_code(key_code), .key_valid(key_valid), .key_pop(key_pop),
        .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row = 4'b1111;
        if (force_row_low) row = 4'b0000;
        else
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c] && !column[c]) row[r] = 1'b0;
    end

    function automatic logic [3:0] code_of(input logic [15:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 16; i++) if (k[i]) c = 4'(i);
        return c;
    endfunction

    function automatic logic [3:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : 4'd0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        hist.delete();
        acc     = 16'd0;
        exp_ovf = 1'b0;
    endtask

    // A key set is accepted once the last DB frames all showed it and it is not a multi-press.
    task automatic model_frame(input logic [15:0] keys, input bit pop);
        bit same;
        if (pop && exp_q.size() > 0) exp_q.delete(0);
        hist.push_back(keys);
        if (hist.size() > DB) hist.delete(0);
        same = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] != keys) same = 0;
        if (same && $countones(keys) <= 1 && keys != acc) begin
            acc = keys;
            if (keys != 16'd0) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(code_of(keys));
                else exp_ovf = 1'b1;
            end
        end
    endtask

    // Presents keys for one frame; pop_mode 1 pops at frame start, 2 pops during EVAL.
    task automatic do_frame(input logic [15:0] keys, input int pop_mode);
        logic [3:0] pc;
        bit         found;
        pressed = keys;
        if (pop_mode == 1) begin
            key_pop = 1'b1;
            @(negedge clk);
            key_pop = 1'b0;
        end
        pc    = column;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (pc == 4'b0111 && column == 4'b1111) found = 1;
            else pc = column;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL frame_sync: no end of frame seen, column=%b", column);
        end
        if (pop_mode == 2) key_pop = 1'b1;
        model_frame(keys, pop_mode != 0);
        @(negedge clk);
        key_pop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; force_row_low = 1'b1; pressed = 16'd0;
        key_pop = 1'b0; overflow_clr = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++; if (column !== 4'b1111) begin n_err++; $display("FAIL reset_column: got %b want 1111", column); end
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_vec++; if (interrupt !== 1'b0 || key_code !== 4'd0) begin n_err++; $display("FAIL reset_irq_code: got %b/%0d want 0/0", interrupt, key_code); end
        force_row_low = 1'b0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        n_vec++; if (column !== 4'b1110) begin n_err++; $display("FAIL scan_start: got %b want 1110", column); end
    endtask

    task automatic test_single_press();
        for (int f = 0; f < 10; f++) begin
            do_frame(16'h0200, 0);
            n_vec++; if (fifo_count !== 5'(exp_q.size())) begin n_err++; $display("FAIL single_count f%0d: got %0d want %0d", f, fifo_count, exp_q.size()); end
        end
        n_vec++; if (fifo_count !== 5'd1 || key_code !== 4'd9) begin n_err++; $display("FAIL single_push: got count %0d code %0d want 1/9", fifo_count, key_code); end
        n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL single_irq: got %b want 1", interrupt); end
        do_frame(16'h0000, 1);
        n_vec++; if (key_valid !== 1'b0 || fifo_count !== 5'd0) begin n_err++; $display("FAIL single_pop: got valid %b count %0d want 0/0", key_valid, fifo_count); end
        repeat (3) do_frame(16'h0000, 0);
    endtask

    task automatic test_bounce();
        logic [15:0] seq [7];
        seq = '{16'h0200, 16'h0000, 16'h0200, 16'h0000, 16'h0200, 16'h0200, 16'h0200};
        for (int f = 0; f < 7; f++) begin
            do_frame(seq[f], 0);
            n_vec++; if (fifo_count !== 5'(exp_q.size())) begin n_err++; $display("FAIL bounce_count f%0d: got %0d want %0d", f, fifo_count, exp_q.size()); end
            if (f == 5) begin
                n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL bounce_early: got %0d want 0", fifo_count); end
            end
        end
        n_vec++; if (fifo_count !== 5'd1 || key_code !== 4'd9) begin n_err++; $display("FAIL bounce_push: got count %0d code %0d want 1/9", fifo_count, key_code); end
        repeat (3) do_frame(16'h0200, 0);
        n_vec++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL bounce_repeat: got %0d want 1", fifo_count); end
        do_frame(16'h0000, 1);
        repeat (3) do_frame(16'h0000, 0);
    endtask

    task automatic test_multi_key();
        for (int f = 0; f < 6; f++) do_frame(16'h0240, 0);
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL multi_count: got %0d want 0", fifo_count); end
        repeat (3) do_frame(16'h0000, 0);
    endtask

    task automatic test_overflow();
        logic [3:0] codes [5];
        codes = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd3};
        for (int k = 0; k < 5; k++) begin
            repeat (3) do_frame(16'(1) << codes[k], 0);
            repeat (3) do_frame(16'h0000, 0);
        end
        n_vec++; if (fifo_count !== 5'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (key_code !== codes[k]) begin n_err++; $display("FAIL ovf_pop%0d: got %0d want %0d", k, key_code, codes[k]); end
            do_frame(16'h0000, 1);
        end
        n_vec++; if (fifo_count !== 5'd0 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drain: got %0d/%b want 0/1", fifo_count, overflow); end
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        exp_ovf = 1'b0;
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_pop_push();
        do_frame(16'h0000, 0);
        for (int k = 0; k < 4; k++) begin
            repeat (3) do_frame(16'(1) << (1 << k), 0);
            repeat (3) do_frame(16'h0000, 0);
        end
        n_vec++; if (fifo_count !== 5'd4) begin n_err++; $display("FAIL full_fill: got %0d want 4", fifo_count); end
        do_frame(16'h0008, 0);
        do_frame(16'h0008, 0);
        do_frame(16'h0008, 2);
        n_vec++; if (fifo_count !== 5'd4 || overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_push: got %0d/%b want 4/0", fifo_count, overflow); end
        n_vec++; if (key_code !== 4'd2) begin n_err++; $display("FAIL full_head: got %0d want 2", key_code); end
        n_vec++; if (fifo_count !== 5'(exp_q.size()) || key_code !== exp_head()) begin n_err++; $display("FAIL full_model: got %0d/%0d want %0d/%0d", fifo_count, key_code, exp_q.size(), exp_head()); end
        repeat (3) do_frame(16'h0000, 0);
        do_frame(16'h0080, 0);
        do_frame(16'h0080, 0);
        reset = 1'b0;
        pressed = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL midreset_clear: got %0d want 0", fifo_count); end
        for (int f = 0; f < 4; f++) do_frame(16'h0000, 0);
        n_vec++; if (fifo_count !== 5'd0 || key_valid !== 1'b0) begin n_err++; $display("FAIL midreset_push: got %0d/%b want 0/0", fifo_count, key_valid); end
    endtask

    task automatic test_random();
        logic [15:0] keys;
        int          kind, len, k1, k2, pm;
        for (int seg = 0; seg < 30; seg++) begin
            kind = $urandom_range(0, 9);
            k1   = $urandom_range(0, 15);
            k2   = (k1 + $urandom_range(1, 15)) % 16;
            if (kind <= 5)      keys = 16'(1) << k1;
            else if (kind <= 7) keys = 16'd0;
            else                keys = (16'(1) << k1) | (16'(1) << k2);
            len = $urandom_range(1, 5);
            for (int f = 0; f < len; f++) begin
                pm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                do_frame(keys, pm);
                n_vec++; if (fifo_count !== 5'(exp_q.size())) begin n_err++; $display("FAIL rand_count s%0d: got %0d want %0d", seg, fifo_count, exp_q.size()); end
                n_vec++; if (key_code !== exp_head()) begin n_err++; $display("FAIL rand_code s%0d: got %0d want %0d", seg, key_code, exp_head()); end
                n_vec++; if (overflow !== exp_ovf) begin n_err++; $display("FAIL rand_ovf s%0d: got %b want %b", seg, overflow, exp_ovf); end
                n_vec++; if (interrupt !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rand_irq s%0d: got %b want %b", seg, interrupt, exp_q.size() > 0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_overflow();
        test_full_pop_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
